tx_memory: RTL

//  Transmit-side counterpart of rx_memory: streams g_pages 32-bit configuration pages (switch configuration per

---
 rtl/tx_memory.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tx_memory.sv
// Streams g_pages 32-bit pages as 16-bit words: sync, hi/lo per page, checksum.
// Frames repeat forever so the far end can realign without a request channel.
package tx_memory_pkg;
   typedef struct packed {
      logic clk;
      logic reset;
   } ckrs_t;
endpackage

module tx_memory
   import tx_memory_pkg::*;
#(
   parameter int          g_pages = 16,
   parameter logic [15:0] g_sync  = 16'hCAFE
) (
   input  ckrs_t                    ClkRs_ix,
   input  logic                     enable_i,
   input  logic [g_pages-1:0][31:0] data_ib32,
   input  logic                     resync_i,
   output logic [15:0]              data_ob16,
   output logic                     word_valid_o,
   output logic                     frame_start_o,
   output logic [15:0]              frame_count_ob16
);

   localparam int PW = (g_pages > 1) ? $clog2(g_pages) : 1;
   localparam logic [PW-1:0] LAST = PW'(g_pages - 1);

   typedef enum logic [1:0] {
      S_SYNC,
      S_HI,
      S_LO,
      S_CHK
   } state_t;

   logic                     clk;
   logic                     rst;
   state_t                   state;
   state_t                   nxt;
   logic [g_pages-1:0][31:0] shadow;
   logic [15:0]              acc;
   logic [PW-1:0]            page;
   logic [31:0]              page_word;
   logic                     strobe;
   logic [15:0]              word;

   assign clk    = ClkRs_ix.clk;
   assign rst    = ClkRs_ix.reset;
   assign strobe = enable_i & ~resync_i;

   always_ff @(posedge clk) begin
      if (rst || resync_i) begin
         state <= S_SYNC;
      end else if (enable_i) begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_SYNC: nxt = S_HI;
         S_HI:   nxt = S_LO;
         S_LO:   nxt = (page == LAST) ? S_CHK : S_HI;
         S_CHK:  nxt = S_SYNC;
         default: nxt = S_SYNC;
      endcase
   end

   // Mux by compare so a 1-bit index never overruns a single-page shadow.
   always_comb begin
      page_word = '0;
      for (int i = 0; i < g_pages; i++) begin
         if (page == PW'(i)) page_word = shadow[i];
      end
   end

   always_comb begin
      word = '0;
      unique case (state)
         S_SYNC: word = g_sync;
         S_HI:   word = page_word[31:16];
         S_LO:   word = page_word[15:0];
         S_CHK:  word = acc;
         default: word = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow           <= '0;
         acc              <= '0;
         page             <= '0;
         frame_count_ob16 <= '0;
         data_ob16        <= '0;
         word_valid_o     <= 1'b0;
         frame_start_o    <= 1'b0;
      end else begin
         word_valid_o  <= strobe;
         frame_start_o <= strobe && (state == S_SYNC);
         if (resync_i) begin
            acc  <= '0;
            page <= '0;
         end else if (enable_i) begin
            data_ob16 <= word;
            unique case (state)
               S_SYNC: begin
                  shadow <= data_ib32;
                  acc    <= '0;
                  page   <= '0;
               end
               S_HI: acc <= acc + word;
               S_LO: begin
                  acc <= acc + word;
                  if (page != LAST) page <= page + 1'b1;
               end
               S_CHK: frame_count_ob16 <= frame_count_ob16 + 16'd1;
               default: ;
            endcase
         end
      end
   end

endmodule
